// File: rtl/apb_rw_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : apb_rw_arbiter
//  Purpose  : Shares one APB transactor between the AXI4-Lite write and read
//             paths. Accepts one request at a time, round-robin on a tie,
//             issues it as a transactor command and routes the completion
//             back to the side that asked for it.
//  Revision : 1.0 - initial release
// ============================================================================
module apb_rw_arbiter #(
   parameter int dataWidth = 32,
   parameter int addrWidth = 32
) (
   input  logic                     clk,
   input  logic                     rst,

   // write request / completion
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic [addrWidth-1:0]     wr_addr,
   input  logic [dataWidth-1:0]     wr_data,
   input  logic [dataWidth/8-1:0]   wr_strb,
   input  logic [2:0]               wr_prot,
   output logic                     wr_resp_valid,
   input  logic                     wr_resp_ready,
   output logic                     wr_resp_err,

   // read request / completion
   input  logic                     rd_valid,
   output logic                     rd_ready,
   input  logic [addrWidth-1:0]     rd_addr,
   input  logic [2:0]               rd_prot,
   output logic                     rd_resp_valid,
   input  logic                     rd_resp_ready,
   output logic [dataWidth-1:0]     rd_resp_data,
   output logic                     rd_resp_err,

   // command to the APB transactor
   output logic                     cmd_valid,
   input  logic                     cmd_ready,
   output logic                     cmd_write,
   output logic [addrWidth-1:0]     cmd_addr,
   output logic [dataWidth-1:0]     cmd_wdata,
   output logic [dataWidth/8-1:0]   cmd_strb,
   output logic [2:0]               cmd_prot,

   // completion from the APB transactor
   input  logic                     rsp_valid,
   input  logic [dataWidth-1:0]     rsp_rdata,
   input  logic                     rsp_slverr
);

   localparam int   c_STRB_W   = dataWidth / 8;
   localparam logic c_GRANT_RD = 1'b0;
   localparam logic c_GRANT_WR = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_ISSUE    = 2'd1,
      S_WAIT_RSP = 2'd2,
      S_RESP     = 2'd3
   } state_t;

   state_t                 r_state;
   logic                   r_last_grant;

   logic                   r_cmd_valid;
   logic                   r_cmd_write;
   logic [addrWidth-1:0]   r_cmd_addr;
   logic [dataWidth-1:0]   r_cmd_wdata;
   logic [c_STRB_W-1:0]    r_cmd_strb;
   logic [2:0]             r_cmd_prot;

   logic                   r_wr_resp_valid;
   logic                   r_wr_resp_err;
   logic                   r_rd_resp_valid;
   logic [dataWidth-1:0]   r_rd_resp_data;
   logic                   r_rd_resp_err;

   logic                   w_idle;
   logic                   w_grant_wr;
   logic                   w_grant_rd;
   logic                   w_resp_hs;

   // Arbitration: a lone request wins outright; on a tie the side that was
   // not granted last time wins. Readies are gated by reset so nothing is
   // accepted while the block is being cleared.
   assign w_idle     = (r_state == S_IDLE) && !rst;
   assign w_grant_wr = w_idle && wr_valid && (!rd_valid || (r_last_grant == c_GRANT_RD));
   assign w_grant_rd = w_idle && rd_valid && (!wr_valid || (r_last_grant == c_GRANT_WR));

   // Only the side that is currently being answered can close the response.
   assign w_resp_hs  = (r_wr_resp_valid && wr_resp_ready) ||
                       (r_rd_resp_valid && rd_resp_ready);

   assign wr_ready      = w_grant_wr;
   assign rd_ready      = w_grant_rd;

   assign cmd_valid     = r_cmd_valid;
   assign cmd_write     = r_cmd_write;
   assign cmd_addr      = r_cmd_addr;
   assign cmd_wdata     = r_cmd_wdata;
   assign cmd_strb      = r_cmd_strb;
   assign cmd_prot      = r_cmd_prot;

   assign wr_resp_valid = r_wr_resp_valid;
   assign wr_resp_err   = r_wr_resp_err;
   assign rd_resp_valid = r_rd_resp_valid;
   assign rd_resp_data  = r_rd_resp_data;
   assign rd_resp_err   = r_rd_resp_err;

   // Transaction FSM with all command/response outputs registered; one
   // transaction is in flight from acceptance until its response handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= S_IDLE;
         r_last_grant    <= c_GRANT_RD;
         r_cmd_valid     <= 1'b0;
         r_cmd_write     <= 1'b0;
         r_cmd_addr      <= '0;
         r_cmd_wdata     <= '0;
         r_cmd_strb      <= '0;
         r_cmd_prot      <= '0;
         r_wr_resp_valid <= 1'b0;
         r_wr_resp_err   <= 1'b0;
         r_rd_resp_valid <= 1'b0;
         r_rd_resp_data  <= '0;
         r_rd_resp_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant_wr || w_grant_rd) begin
                  r_state      <= S_ISSUE;
                  r_cmd_valid  <= 1'b1;
                  r_cmd_write  <= w_grant_wr;
                  r_last_grant <= w_grant_wr ? c_GRANT_WR : c_GRANT_RD;
                  if (w_grant_wr) begin
                     r_cmd_addr  <= wr_addr;
                     r_cmd_wdata <= wr_data;
                     r_cmd_strb  <= wr_strb;
                     r_cmd_prot  <= wr_prot;
                  end else begin
                     // reads carry no payload towards the transactor
                     r_cmd_addr  <= rd_addr;
                     r_cmd_wdata <= '0;
                     r_cmd_strb  <= '0;
                     r_cmd_prot  <= rd_prot;
                  end
               end
            end

            S_ISSUE: begin
               if (cmd_ready) begin
                  r_cmd_valid <= 1'b0;
                  r_state     <= S_WAIT_RSP;
               end
            end

            S_WAIT_RSP: begin
               if (rsp_valid) begin
                  r_state <= S_RESP;
                  if (r_cmd_write) begin
                     r_wr_resp_valid <= 1'b1;
                     r_wr_resp_err   <= rsp_slverr;
                  end else begin
                     r_rd_resp_valid <= 1'b1;
                     r_rd_resp_err   <= rsp_slverr;
                     r_rd_resp_data  <= rsp_rdata;
                  end
               end
            end

            S_RESP: begin
               if (w_resp_hs) begin
                  r_wr_resp_valid <= 1'b0;
                  r_rd_resp_valid <= 1'b0;
                  r_state         <= S_IDLE;
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_apb_rw_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_rw_arbiter
//  Purpose  : Scoreboard bench for apb_rw_arbiter. The stimulus process plays
//             both AXI sides and the APB transactor and queues the expected
//             grants, commands and responses; a negedge monitor checks them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apb_rw_arbiter;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int SW = DW / 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_valid, wr_ready, wr_resp_valid, wr_resp_ready, wr_resp_err;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [SW-1:0] wr_strb;
   logic [2:0]    wr_prot;
   logic          rd_valid, rd_ready, rd_resp_valid, rd_resp_ready, rd_resp_err;
   logic [AW-1:0] rd_addr;
   logic [2:0]    rd_prot;
   logic [DW-1:0] rd_resp_data;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic [SW-1:0] cmd_strb;
   logic [2:0]    cmd_prot;
   logic          rsp_valid, rsp_slverr;
   logic [DW-1:0] rsp_rdata;

   always #5 clk = ~clk;

   apb_rw_arbiter #(.dataWidth(DW), .addrWidth(AW)) dut (
      .clk(clk), .rst(rst),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_strb(wr_strb), .wr_prot(wr_prot), .wr_resp_valid(wr_resp_valid),
      .wr_resp_ready(wr_resp_ready), .wr_resp_err(wr_resp_err),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_prot(rd_prot),
      .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready),
      .rd_resp_data(rd_resp_data), .rd_resp_err(rd_resp_err),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr)
   );

   typedef struct packed {
      logic          write;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [SW-1:0] strb;
      logic [2:0]    prot;
   } cmd_t;

   typedef struct packed {
      logic          write;
      logic [DW-1:0] data;
      logic          err;
   } rsp_t;

   cmd_t cmd_q[$];
   rsp_t rsp_q[$];
   logic grant_q[$];          // 1 = write side expected, 0 = read side

   int   n_cmp = 0;
   int   n_bad = 0;
   logic busy  = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (rst) begin
         busy = 1'b0;
      end else begin
         if (wr_ready || rd_ready) begin
            check("one_ready", {63'd0, wr_ready & rd_ready}, 64'd0);
            check("ready_while_busy", {63'd0, busy}, 64'd0);
            if (grant_q.size() == 0) begin
               check("unexpected_grant", 64'd1, 64'd0);
            end else begin
               check("grant_dir", {63'd0, wr_ready}, {63'd0, grant_q.pop_front()});
            end
            busy = 1'b1;
         end
         if (cmd_valid) begin
            if (cmd_q.size() == 0) begin
               check("unexpected_cmd", 64'd1, 64'd0);
            end else begin
               check("cmd_write", {63'd0, cmd_write}, {63'd0, cmd_q[0].write});
               check("cmd_addr",  {32'd0, cmd_addr},  {32'd0, cmd_q[0].addr});
               check("cmd_wdata", {32'd0, cmd_wdata}, {32'd0, cmd_q[0].wdata});
               check("cmd_strb",  {60'd0, cmd_strb},  {60'd0, cmd_q[0].strb});
               check("cmd_prot",  {61'd0, cmd_prot},  {61'd0, cmd_q[0].prot});
               if (cmd_ready) void'(cmd_q.pop_front());
            end
         end
         if (wr_resp_valid || rd_resp_valid) begin
            check("one_resp", {63'd0, wr_resp_valid & rd_resp_valid}, 64'd0);
            if (rsp_q.size() == 0) begin
               check("unexpected_resp", 64'd1, 64'd0);
            end else begin
               check("resp_dir", {63'd0, wr_resp_valid}, {63'd0, rsp_q[0].write});
               if (rsp_q[0].write) begin
                  check("wr_resp_err", {63'd0, wr_resp_err}, {63'd0, rsp_q[0].err});
               end else begin
                  check("rd_resp_data", {32'd0, rd_resp_data}, {32'd0, rsp_q[0].data});
                  check("rd_resp_err",  {63'd0, rd_resp_err},  {63'd0, rsp_q[0].err});
               end
               if ((wr_resp_valid && wr_resp_ready) || (rd_resp_valid && rd_resp_ready)) begin
                  void'(rsp_q.pop_front());
                  busy = 1'b0;
               end
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic push_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [SW-1:0] s, input logic [2:0] p);
      cmd_t c;
      c.write = w; c.addr = a; c.wdata = d; c.strb = s; c.prot = p;
      cmd_q.push_back(c);
   endtask

   // Waits for a request handshake; returns one cycle later with cmd_valid due.
   task automatic wait_grant();
      bit ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (wr_ready || rd_ready) begin
            ok = 1'b1;
            break;
         end
      end
      check("grant_seen", {63'd0, ok}, 64'd1);
      tick();
      check("cmd_latency", {63'd0, cmd_valid}, 64'd1);
   endtask

   task automatic serve_cmd(input int delay, input bit spurious);
      bit ok = 1'b0;
      for (int i = 0; i < delay; i++) begin
         if (spurious && i == 1) begin
            rsp_valid = 1'b1; rsp_rdata = 32'hBADBAD00; rsp_slverr = 1'b1;
         end
         tick();
         rsp_valid = 1'b0;
      end
      cmd_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (cmd_valid) begin
            ok = 1'b1;
            break;
         end
      end
      check("cmd_hs_seen", {63'd0, ok}, 64'd1);
      tick();
      cmd_ready = 1'b0;
   endtask

   task automatic serve_rsp(input int delay, input logic is_wr, input logic [DW-1:0] rdata,
                            input logic err);
      rsp_t e;
      repeat (delay) tick();
      e.write = is_wr; e.data = rdata; e.err = err;
      rsp_q.push_back(e);
      rsp_valid = 1'b1; rsp_rdata = rdata; rsp_slverr = err;
      tick();
      rsp_valid = 1'b0; rsp_rdata = ~rdata; rsp_slverr = ~err;
      check("resp_latency", {63'd0, is_wr ? wr_resp_valid : rd_resp_valid}, 64'd1);
   endtask

   task automatic serve_resp(input int delay, input logic is_wr);
      bit ok = 1'b0;
      repeat (delay) tick();
      if (is_wr) wr_resp_ready = 1'b1;
      else       rd_resp_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (is_wr ? wr_resp_valid : rd_resp_valid) begin
            ok = 1'b1;
            break;
         end
      end
      check("resp_hs_seen", {63'd0, ok}, 64'd1);
      tick();
      wr_resp_ready = 1'b0;
      rd_resp_ready = 1'b0;
   endtask

   task automatic check_reset_outs();
      check("rst_wr_ready",      {63'd0, wr_ready},      64'd0);
      check("rst_rd_ready",      {63'd0, rd_ready},      64'd0);
      check("rst_wr_resp_valid", {63'd0, wr_resp_valid}, 64'd0);
      check("rst_wr_resp_err",   {63'd0, wr_resp_err},   64'd0);
      check("rst_rd_resp_valid", {63'd0, rd_resp_valid}, 64'd0);
      check("rst_rd_resp_data",  {32'd0, rd_resp_data},  64'd0);
      check("rst_rd_resp_err",   {63'd0, rd_resp_err},   64'd0);
      check("rst_cmd_valid",     {63'd0, cmd_valid},     64'd0);
      check("rst_cmd_write",     {63'd0, cmd_write},     64'd0);
      check("rst_cmd_addr",      {32'd0, cmd_addr},      64'd0);
      check("rst_cmd_wdata",     {32'd0, cmd_wdata},     64'd0);
      check("rst_cmd_strb",      {60'd0, cmd_strb},      64'd0);
      check("rst_cmd_prot",      {61'd0, cmd_prot},      64'd0);
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      rst = 1'b1;
      wr_valid = 0; wr_addr = '0; wr_data = '0; wr_strb = '0; wr_prot = '0; wr_resp_ready = 0;
      rd_valid = 0; rd_addr = '0; rd_prot = '0; rd_resp_ready = 0;
      cmd_ready = 0; rsp_valid = 0; rsp_rdata = '0; rsp_slverr = 0;
      repeat (3) tick();
      check_reset_outs();
      rst = 1'b0;
      tick();

      // single write
      wr_addr = 32'h10; wr_data = 32'hDEADBEEF; wr_strb = 4'hF; wr_prot = 3'd0; wr_valid = 1;
      grant_q.push_back(1'b1);
      push_cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'd0);
      wait_grant();
      wr_valid = 0;
      serve_cmd(0, 1'b0);
      serve_rsp(1, 1'b1, 32'h0, 1'b0);
      serve_resp(0, 1'b1);

      // single read; stale write-side data must not leak into the command
      wr_data = 32'hFFFFFFFF; wr_strb = 4'hF;
      rd_addr = 32'h20; rd_prot = 3'b010; rd_valid = 1;
      grant_q.push_back(1'b0);
      push_cmd(1'b0, 32'h20, 32'h0, 4'h0, 3'b010);
      wait_grant();
      rd_valid = 0;
      serve_cmd(2, 1'b0);
      serve_rsp(0, 1'b0, 32'h12345678, 1'b1);
      serve_resp(1, 1'b0);

      // spurious completion while idle
      tick();
      rsp_valid = 1; rsp_rdata = 32'h0000CAFE; rsp_slverr = 1;
      tick();
      rsp_valid = 0;
      repeat (3) tick();
      check("idle_after_spurious", {63'd0, cmd_valid}, 64'd0);

      // back-pressure on command and response, with a write waiting behind
      rd_addr = 32'h44; rd_prot = 3'd1; rd_valid = 1;
      grant_q.push_back(1'b0);
      push_cmd(1'b0, 32'h44, 32'h0, 4'h0, 3'd1);
      wait_grant();
      rd_valid = 0;
      wr_addr = 32'h48; wr_data = 32'hA5A55A5A; wr_strb = 4'h3; wr_prot = 3'd4; wr_valid = 1;
      grant_q.push_back(1'b1);
      push_cmd(1'b1, 32'h48, 32'hA5A55A5A, 4'h3, 3'd4);
      serve_cmd(5, 1'b1);
      serve_rsp(0, 1'b0, 32'h0BADF00D, 1'b0);
      serve_resp(4, 1'b0);
      wait_grant();
      wr_valid = 0;
      serve_cmd(0, 1'b0);
      serve_rsp(0, 1'b1, 32'h0, 1'b1);
      serve_resp(0, 1'b1);

      // contention straight after reset: write, read, write, read
      rst = 1; tick(); rst = 0;
      wr_addr = 32'h100; wr_data = 32'h11111111; wr_strb = 4'hF; wr_prot = 3'd0;
      rd_addr = 32'h200; rd_prot = 3'd0;
      wr_valid = 1; rd_valid = 1;
      for (int k = 0; k < 4; k++) begin
         grant_q.push_back((k % 2) == 0);
         if ((k % 2) == 0) push_cmd(1'b1, 32'h100, 32'h11111111, 4'hF, 3'd0);
         else              push_cmd(1'b0, 32'h200, 32'h0, 4'h0, 3'd0);
      end
      for (int k = 0; k < 4; k++) begin
         wait_grant();
         if (k == 3) begin
            wr_valid = 0; rd_valid = 0;
         end
         serve_cmd(0, 1'b0);
         serve_rsp(0, (k % 2) == 0, 32'h50000000 + k, k[0]);
         serve_resp(0, (k % 2) == 0);
      end

      // reset during WAIT_RSP drops the write; next tie goes to write again
      wr_addr = 32'h80; wr_data = 32'h80808080; wr_strb = 4'hF; wr_prot = 3'd2; wr_valid = 1;
      grant_q.push_back(1'b1);
      push_cmd(1'b1, 32'h80, 32'h80808080, 4'hF, 3'd2);
      wait_grant();
      wr_valid = 0;
      serve_cmd(0, 1'b0);
      tick();
      rst = 1; tick(); rst = 0;
      check_reset_outs();
      rsp_valid = 1; rsp_rdata = 32'h77777777; rsp_slverr = 0;
      tick();
      rsp_valid = 0;
      repeat (5) tick();
      wr_addr = 32'h90; wr_data = 32'h90909090; wr_strb = 4'h5; wr_prot = 3'd0; wr_valid = 1;
      rd_addr = 32'h94; rd_prot = 3'd0; rd_valid = 1;
      grant_q.push_back(1'b1);
      push_cmd(1'b1, 32'h90, 32'h90909090, 4'h5, 3'd0);
      wait_grant();
      wr_valid = 0; rd_valid = 0;
      serve_cmd(0, 1'b0);
      serve_rsp(0, 1'b1, 32'h0, 1'b0);
      serve_resp(0, 1'b1);

      repeat (3) tick();
      check("queues_drained", 64'(grant_q.size() + cmd_q.size() + rsp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
      $fatal(1);
   end

endmodule
`default_nettype wire
